// File: rtl/imem_loader_if.sv
// Source-stream and instruction-memory write bundle for imem_loader.
// A word transfers on a rising edge where s_valid && s_ready; the source holds s_data stable while s_valid is high.
interface imem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              we0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [DATA_W-1:0] wr_din0;

    modport master (
        output s_valid, s_data,
        input  s_ready, we0, wr_addr0, wr_din0
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, we0, wr_addr0, wr_din0
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, holds the PC in reset while loading,
// then releases it for an optional cycle budget.
module imem_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int MAX_WORDS  = 128,
    parameter int BYTE_ADDR  = 1,
    parameter int PC_HOLD    = 2,
    parameter int RUN_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    imem_loader_if.slave      bus,
    output logic              resetpc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] wc;
    logic [31:0]       hold_cnt;
    logic [31:0]       run_cnt;

    logic legal;
    logic xfer;
    logic last;
    logic hold_done;
    logic run_exit;
    logic start_load;
    logic reject;

    assign legal     = (word_count != '0) && (32'(word_count) <= 32'(MAX_WORDS));
    assign xfer      = (state == S_LOAD) && bus.s_valid;
    assign last      = xfer && (idx == wc - ADDR_W'(1));
    // RELEASE is entered together with the final write, so that cycle counts toward the hold.
    assign hold_done = (hold_cnt + 32'd1) >= 32'(PC_HOLD);
    assign run_exit  = (RUN_CYCLES != 0) && (run_cnt == 32'(RUN_CYCLES) - 32'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_load = 1'b0;
        reject     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_next = S_LOAD;
                        start_load = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (last) begin
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (hold_done) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (start && legal) begin
                    state_next = S_LOAD;
                    start_load = 1'b1;
                end else begin
                    reject = start;
                    if (run_exit) begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.s_ready = (state == S_LOAD);
    assign busy        = (state != S_IDLE);
    assign resetpc     = (state == S_RUN);
    assign state_dbg   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx          <= '0;
            wc           <= '0;
            hold_cnt     <= '0;
            run_cnt      <= '0;
            bus.we0      <= 1'b0;
            bus.wr_addr0 <= '0;
            bus.wr_din0  <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            bus.we0 <= xfer;
            done    <= (state == S_RUN) && (state_next == S_IDLE);
            err     <= reject;

            if (start_load) begin
                idx <= '0;
                wc  <= word_count;
            end else if (xfer && !last) begin
                idx <= idx + ADDR_W'(1);
            end

            if (xfer) begin
                bus.wr_addr0 <= (BYTE_ADDR != 0) ? (idx << 2) : idx;
                bus.wr_din0  <= bus.s_data;
            end

            if (state == S_RELEASE && state_next == S_RELEASE) begin
                hold_cnt <= hold_cnt + 32'd1;
            end else begin
                hold_cnt <= '0;
            end

            // Counter restarts from 0 on every entry to RUN and saturates rather than wrapping.
            if (state == S_RUN && state_next == S_RUN) begin
                if (run_cnt != '1) begin
                    run_cnt <= run_cnt + 32'd1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule
